// File: rtl/uart_rx.sv
// UART receiver: oversampled serial input, 3-sample mid-bit majority vote,
// optional even/odd parity, stop-bit check and one-cycle result strobes.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);

  logic [2:0]            r_state;
  logic [5:0]            r_edge_cnt;
  logic [CW-1:0]         r_bit_cnt;
  logic [5:0]            r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_flag;
  logic [2:0]            r_samp;
  logic [DATA_WIDTH-1:0] r_shift;

  logic [5:0] w_pre_dec;
  logic [5:0] w_half;
  logic [5:0] w_last;
  logic       w_sample;
  logic       w_bit_end;
  logic       w_maj;
  logic       w_par_exp;

  // Unsupported ratios fall back to 8 so the bit timing is always well defined.
  assign w_pre_dec = (Prescale == 6'd16 || Prescale == 6'd32) ? Prescale : 6'd8;
  assign w_half    = {1'b0, r_prescale[5:1]};
  assign w_last    = r_prescale - 6'd1;
  assign w_sample  = (r_edge_cnt == w_half - 6'd1) || (r_edge_cnt == w_half) ||
                     (r_edge_cnt == w_half + 6'd1);
  assign w_bit_end = (r_edge_cnt == w_last);
  assign w_maj     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) |
                     (r_samp[1] & r_samp[2]);
  assign w_par_exp = r_par_typ ? ~^r_shift : ^r_shift;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_edge_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_prescale   <= 6'd8;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_par_flag   <= 1'b0;
      r_samp       <= '0;
      r_shift      <= '0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;

      if (r_state != IDLE) begin
        r_edge_cnt <= w_bit_end ? 6'd0 : r_edge_cnt + 6'd1;
        if (w_sample)
          r_samp <= {r_samp[1:0], RX_IN};
      end

      case (r_state)
        IDLE: begin
          // The detect cycle itself is edge 0 of the start bit.
          if (!RX_IN) begin
            r_state    <= START;
            r_edge_cnt <= 6'd1;
            r_prescale <= w_pre_dec;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state   <= w_maj ? IDLE : DATA;
            r_bit_cnt <= '0;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= r_par_en ? PARITY : STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_par_flag <= (w_maj != w_par_exp);
            r_state    <= STOP;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            stop_error   <= ~w_maj;
            parity_error <= r_par_flag;
            r_par_flag   <= 1'b0;
            if (w_maj && !r_par_flag) begin
              P_DATA     <= r_shift;
              data_valid <= 1'b1;
            end
            // A low line on the stop bit's last cycle starts the next frame.
            if (!RX_IN) begin
              r_state    <= START;
              r_edge_cnt <= 6'd1;
              r_prescale <= w_pre_dec;
              r_par_en   <= PAR_EN;
              r_par_typ  <= PAR_TYP;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: frame timing, parity/stop errors,
// glitch rejection, back-to-back frames and mid-frame reset.
module tb_uart_rx;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;

  int checks   = 0;
  int failures = 0;
  int cycleCount = 0;

  int         validCycles[$];
  logic [7:0] validData[$];
  int         parCycles[$];
  int         stopCycles[$];

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .Prescale     (Prescale),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .stop_error   (stop_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cycleCount <= cycleCount + 1;

  // Record every strobe with the cycle it was seen in.
  always @(negedge CLK) begin
    if (data_valid === 1'b1) begin
      validCycles.push_back(cycleCount);
      validData.push_back(P_DATA);
    end
    if (parity_error === 1'b1) parCycles.push_back(cycleCount);
    if (stop_error === 1'b1) stopCycles.push_back(cycleCount);
  end

  // Caller must be at posedge+#1; start bit low begins in cycle startCycle.
  task automatic send_frame(input logic [7:0] data, input int p, input bit parEn,
                            input bit parBit, input bit stopBit, output int startCycle);
    startCycle = cycleCount;
    RX_IN = 1'b0;
    repeat (p) @(posedge CLK);
    #1;
    for (int i = 0; i < 8; i++) begin
      RX_IN = data[i];
      repeat (p) @(posedge CLK);
      #1;
    end
    if (parEn) begin
      RX_IN = parBit;
      repeat (p) @(posedge CLK);
      #1;
    end
    RX_IN = stopBit;
    repeat (p) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    idle_cycles(3);
    checks++; if (P_DATA !== 8'h00) begin failures++; $display("[TB] FAIL reset_pdata got %h want 00", P_DATA); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b want 0", data_valid); end
    checks++; if (parity_error !== 1'b0) begin failures++; $display("[TB] FAIL reset_perr got %b want 0", parity_error); end
    checks++; if (stop_error !== 1'b0) begin failures++; $display("[TB] FAIL reset_serr got %b want 0", stop_error); end
    RST = 1'b0;
    idle_cycles(5);
  endtask

  task automatic test_no_parity;
    int s, v0, e0;
    v0 = validCycles.size(); e0 = parCycles.size() + stopCycles.size();
    Prescale = 6'd8; PAR_EN = 1'b0;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, s);
    idle_cycles(20);
    checks++; if (validCycles.size() !== v0 + 1) begin failures++; $display("[TB] FAIL np_count got %0d want %0d", validCycles.size(), v0 + 1); end
    else begin
      checks++; if (validCycles[v0] !== s + 80) begin failures++; $display("[TB] FAIL np_time got %0d want %0d", validCycles[v0], s + 80); end
      checks++; if (validData[v0] !== 8'hA5) begin failures++; $display("[TB] FAIL np_data got %h want a5", validData[v0]); end
    end
    checks++; if (parCycles.size() + stopCycles.size() !== e0) begin failures++; $display("[TB] FAIL np_errors got %0d want %0d", parCycles.size() + stopCycles.size(), e0); end
  endtask

  task automatic test_even_parity;
    int s, v0, e0;
    v0 = validCycles.size(); e0 = parCycles.size() + stopCycles.size();
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, s);
    idle_cycles(20);
    checks++; if (validCycles.size() !== v0 + 1) begin failures++; $display("[TB] FAIL ep_count got %0d want %0d", validCycles.size(), v0 + 1); end
    else begin
      checks++; if (validCycles[v0] !== s + 176) begin failures++; $display("[TB] FAIL ep_time got %0d want %0d", validCycles[v0], s + 176); end
      checks++; if (validData[v0] !== 8'h3C) begin failures++; $display("[TB] FAIL ep_data got %h want 3c", validData[v0]); end
    end
    checks++; if (parCycles.size() + stopCycles.size() !== e0) begin failures++; $display("[TB] FAIL ep_errors got %0d want %0d", parCycles.size() + stopCycles.size(), e0); end
  endtask

  task automatic test_parity_error;
    int s, v0, p0, t0;
    v0 = validCycles.size(); p0 = parCycles.size(); t0 = stopCycles.size();
    Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    send_frame(8'h3C, 32, 1'b1, 1'b0, 1'b1, s);
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    idle_cycles(20);
    checks++; if (parCycles.size() !== p0 + 1) begin failures++; $display("[TB] FAIL pe_count got %0d want %0d", parCycles.size(), p0 + 1); end
    else begin
      checks++; if (parCycles[p0] !== s + 352) begin failures++; $display("[TB] FAIL pe_time got %0d want %0d", parCycles[p0], s + 352); end
    end
    checks++; if (validCycles.size() !== v0) begin failures++; $display("[TB] FAIL pe_novalid got %0d want %0d", validCycles.size(), v0); end
    checks++; if (stopCycles.size() !== t0) begin failures++; $display("[TB] FAIL pe_nostop got %0d want %0d", stopCycles.size(), t0); end
    checks++; if (P_DATA !== 8'h3C) begin failures++; $display("[TB] FAIL pe_hold got %h want 3c", P_DATA); end
  endtask

  task automatic test_stop_error;
    int s, v0, p0, t0;
    v0 = validCycles.size(); p0 = parCycles.size(); t0 = stopCycles.size();
    Prescale = 6'd8; PAR_EN = 1'b0;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, s);
    idle_cycles(40);
    checks++; if (stopCycles.size() !== t0 + 1) begin failures++; $display("[TB] FAIL se_count got %0d want %0d", stopCycles.size(), t0 + 1); end
    else begin
      checks++; if (stopCycles[t0] !== s + 80) begin failures++; $display("[TB] FAIL se_time got %0d want %0d", stopCycles[t0], s + 80); end
    end
    checks++; if (validCycles.size() !== v0) begin failures++; $display("[TB] FAIL se_novalid got %0d want %0d", validCycles.size(), v0); end
    checks++; if (parCycles.size() !== p0) begin failures++; $display("[TB] FAIL se_noperr got %0d want %0d", parCycles.size(), p0); end
    checks++; if (P_DATA !== 8'h3C) begin failures++; $display("[TB] FAIL se_hold got %h want 3c", P_DATA); end
  endtask

  task automatic test_glitch;
    int s, g, v0, e0;
    v0 = validCycles.size(); e0 = parCycles.size() + stopCycles.size();
    Prescale = 6'd16; PAR_EN = 1'b0;
    g = cycleCount;
    RX_IN = 1'b0;
    idle_cycles(3);
    RX_IN = 1'b1;
    idle_cycles(13);
    checks++; if (cycleCount !== g + 16) begin failures++; $display("[TB] FAIL gl_align got %0d want %0d", cycleCount, g + 16); end
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, s);
    idle_cycles(20);
    checks++; if (validCycles.size() !== v0 + 1) begin failures++; $display("[TB] FAIL gl_count got %0d want %0d", validCycles.size(), v0 + 1); end
    else begin
      checks++; if (validCycles[v0] !== s + 160) begin failures++; $display("[TB] FAIL gl_time got %0d want %0d", validCycles[v0], s + 160); end
      checks++; if (validData[v0] !== 8'h81) begin failures++; $display("[TB] FAIL gl_data got %h want 81", validData[v0]); end
    end
    checks++; if (parCycles.size() + stopCycles.size() !== e0) begin failures++; $display("[TB] FAIL gl_errors got %0d want %0d", parCycles.size() + stopCycles.size(), e0); end
  endtask

  task automatic test_back_to_back;
    int s1, s2, v0, e0;
    v0 = validCycles.size(); e0 = parCycles.size() + stopCycles.size();
    Prescale = 6'd8; PAR_EN = 1'b0;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, s1);
    send_frame(8'hEE, 8, 1'b0, 1'b0, 1'b1, s2);
    idle_cycles(2);
    checks++; if (validCycles.size() !== v0 + 2) begin failures++; $display("[TB] FAIL b2b_count got %0d want %0d", validCycles.size(), v0 + 2); end
    else begin
      checks++; if (validCycles[v0] !== s1 + 80) begin failures++; $display("[TB] FAIL b2b_time1 got %0d want %0d", validCycles[v0], s1 + 80); end
      checks++; if (validCycles[v0+1] - validCycles[v0] !== 80) begin failures++; $display("[TB] FAIL b2b_gap got %0d want 80", validCycles[v0+1] - validCycles[v0]); end
      checks++; if (validData[v0] !== 8'h11) begin failures++; $display("[TB] FAIL b2b_data1 got %h want 11", validData[v0]); end
      checks++; if (validData[v0+1] !== 8'hEE) begin failures++; $display("[TB] FAIL b2b_data2 got %h want ee", validData[v0+1]); end
    end
    // Third frame aborted by reset partway through its data bits.
    RX_IN = 1'b0;
    idle_cycles(8);
    RX_IN = 1'b1;
    idle_cycles(8);
    RX_IN = 1'b0;
    idle_cycles(16);
    RST = 1'b1;
    RX_IN = 1'b1;
    #1;
    checks++; if (P_DATA !== 8'h00) begin failures++; $display("[TB] FAIL rst_pdata got %h want 00", P_DATA); end
    idle_cycles(3);
    RST = 1'b0;
    idle_cycles(150);
    checks++; if (validCycles.size() !== v0 + 2) begin failures++; $display("[TB] FAIL rst_nostrobe got %0d want %0d", validCycles.size(), v0 + 2); end
    checks++; if (parCycles.size() + stopCycles.size() !== e0) begin failures++; $display("[TB] FAIL rst_noerr got %0d want %0d", parCycles.size() + stopCycles.size(), e0); end
    checks++; if (P_DATA !== 8'h00) begin failures++; $display("[TB] FAIL rst_pdata_after got %h want 00", P_DATA); end
    checks++; if ({data_valid, parity_error, stop_error} !== 3'b000) begin failures++; $display("[TB] FAIL rst_strobes got %b want 000", {data_valid, parity_error, stop_error}); end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_even_parity();
    test_parity_error();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
